// File: rtl/mvdr_pkg.sv
// Shared constants and helpers for the MVDR front end (framer and FFT feed).
package mvdr_pkg;

    localparam int                 FFT_N     = 256;
    localparam int                 SAMPLE_DW = 16;
    localparam logic signed [15:0] Q15_ONE   = 16'sd32767;
    localparam int                 Q15_ROUND = 2**14;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_WAIT,
        ST_STREAM
    } frame_state_e;

    function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
        if (x > 32'sd32767) begin
            return 16'sh7FFF;
        end else if (x < -32'sd32768) begin
            return 16'sh8000;
        end else begin
            return x[15:0];
        end
    endfunction

endpackage

// File: rtl/fft_frame_window_hann_rom.sv
// Periodic Hann coefficient ROM in Q1.15, one entry per frame index.
// Synchronous read: the coefficient for addr_i appears one cycle later; no flow control.
module hann_rom
    import mvdr_pkg::*;
#(
    parameter int N  = FFT_N,
    parameter int DW = SAMPLE_DW
) (
    input  logic                 clk,
    input  logic [$clog2(N)-1:0] addr_i,
    output logic [DW-1:0]        coef_o
);

    localparam real PI = 3.14159265358979323846;

    function automatic logic [DW-1:0] hann_coef(input int k);
        real c;
        c = $cos(2.0 * PI * real'(k) / real'(N));
        // Quarter points are an exact x.5 tie; force cos to 0 so they round up.
        if ((4 * k == N) || (4 * k == 3 * N)) begin
            c = 0.0;
        end
        return DW'($rtoi(real'(Q15_ONE) * 0.5 * (1.0 - c) + 0.5));
    endfunction

    logic [DW-1:0] rom [N];

    for (genvar g = 0; g < N; g++) begin : g_rom
        assign rom[g] = hann_coef(g);
    end

    always_ff @(posedge clk) begin
        coef_o <= rom[addr_i];
    end

endmodule

// File: rtl/fft_frame_window.sv
// Frames a mic sample stream into N-sample FFT bursts every HOP inputs; 2-cycle read latency, no input
// backpressure (triggers while the FFT is busy are dropped and counted). FRAMER_HANN_EN selects Hann window.
module fft_frame_window
    import mvdr_pkg::*;
#(
    parameter int N   = FFT_N,
    parameter int DW  = SAMPLE_DW,
    parameter int HOP = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] s_data,
    input  logic                 s_valid,
    input  logic                 fft_done,
    output logic signed [DW-1:0] m_data,
    output logic                 m_valid,
    output logic                 m_last,
    output logic                 overrun,
    output logic [15:0]          overrun_cnt
);

    localparam int KW = $clog2(N);
    localparam int AW = KW + 1;
    localparam int HW = $clog2(HOP + 1);

    frame_state_e         state_q, state_d;
    logic [AW-1:0]        wr_ptr_q, rd_base_q, rd_addr;
    logic [KW-1:0]        fill_cnt_q, rd_k_q, rd_k;
    logic [HW-1:0]        hop_cnt_q;
    logic                 fft_busy_q;
    logic                 fill_trig, hop_trig, can_accept, accept, drop, issue, last_issue;
    logic signed [DW-1:0] ram [2*N];
    logic signed [DW-1:0] rdata_q, win_dat, m_data_q;
    logic                 v1_q, last1_q;
    logic                 m_valid_q, m_last_q, overrun_q;
    logic [15:0]          overrun_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FILL: begin
                if (accept) begin
                    state_d = ST_STREAM;
                end else if (fill_trig) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (accept) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (last_issue) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Frame index 0 is issued in the accept cycle itself, so STREAM covers indices 1..N-1.
    always_comb begin
        fill_trig  = (state_q == ST_FILL) && s_valid && (fill_cnt_q == KW'(N - 1));
        hop_trig   = (state_q != ST_FILL) && s_valid && (hop_cnt_q == HW'(HOP - 1));
        can_accept = (state_q != ST_STREAM) && (!fft_busy_q || fft_done);
        accept     = (fill_trig || hop_trig) && can_accept;
        drop       = (fill_trig || hop_trig) && !can_accept;
        issue      = accept || (state_q == ST_STREAM);
        last_issue = (state_q == ST_STREAM) && (rd_k_q == KW'(N - 1));
        rd_k       = accept ? '0 : rd_k_q;
        rd_addr    = accept ? (wr_ptr_q + AW'(1) - AW'(N)) : (rd_base_q + AW'(rd_k_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            hop_cnt_q  <= '0;
            fft_busy_q <= 1'b0;
            rd_base_q  <= '0;
            rd_k_q     <= '0;
        end else begin
            if (s_valid) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if ((state_q == ST_FILL) && s_valid) begin
                fill_cnt_q <= fill_cnt_q + KW'(1);
            end
            if (fill_trig || hop_trig) begin
                hop_cnt_q <= '0;
            end else if ((state_q != ST_FILL) && s_valid) begin
                hop_cnt_q <= hop_cnt_q + HW'(1);
            end
            if (accept) begin
                fft_busy_q <= 1'b1;
            end else if (fft_done) begin
                fft_busy_q <= 1'b0;
            end
            if (accept) begin
                rd_base_q <= rd_addr;
            end
            if (issue) begin
                rd_k_q <= rd_k + KW'(1);
            end
        end
    end

    // Ring buffer of 2N: the frame being read and the incoming writes sit in disjoint halves.
    always_ff @(posedge clk) begin
        if (s_valid) begin
            ram[wr_ptr_q] <= s_data;
        end
        rdata_q <= ram[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
        end else begin
            v1_q    <= issue;
            last1_q <= issue && (rd_k == KW'(N - 1));
        end
    end

`ifdef FRAMER_HANN_EN
    logic [DW-1:0]          coef;
    logic signed [2*DW-1:0] prod;

    hann_rom #(
        .N  (N),
        .DW (DW)
    ) u_hann_rom (
        .clk    (clk),
        .addr_i (rd_k),
        .coef_o (coef)
    );

    always_comb begin
        prod    = (2*DW)'(rdata_q) * (2*DW)'($signed({1'b0, coef})) + (2*DW)'(Q15_ROUND);
        win_dat = sat16(prod >>> 15);
    end
`else
    assign win_dat = rdata_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_q      <= '0;
            m_valid_q     <= 1'b0;
            m_last_q      <= 1'b0;
            overrun_q     <= 1'b0;
            overrun_cnt_q <= '0;
        end else begin
            m_valid_q <= v1_q;
            m_last_q  <= last1_q;
            if (v1_q) begin
                m_data_q <= win_dat;
            end
            overrun_q <= drop;
            if (drop && (overrun_cnt_q != 16'hFFFF)) begin
                overrun_cnt_q <= overrun_cnt_q + 16'd1;
            end
        end
    end

    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign overrun     = overrun_q;
    assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_fft_frame_window.sv
// Bench for fft_frame_window: a HOP=128 and a HOP=1 instance share one stimulus stream and are
// compared cycle by cycle against a frame-level reference model.
module tb_fft_frame_window;

    localparam int N = 256;

    logic                clk = 1'b0;
    logic                rst_n;
    logic signed [15:0]  s_data;
    logic                s_valid;
    logic                fft_done;
    logic signed [15:0]  m_data_w [2];
    logic [1:0]          m_valid_w, m_last_w, overrun_w;
    logic [15:0]         ovr_cnt_w [2];

    always #5 clk = ~clk;

    fft_frame_window #(.N(N), .DW(16), .HOP(128)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .fft_done(fft_done),
        .m_data(m_data_w[0]), .m_valid(m_valid_w[0]), .m_last(m_last_w[0]),
        .overrun(overrun_w[0]), .overrun_cnt(ovr_cnt_w[0])
    );

    fft_frame_window #(.N(N), .DW(16), .HOP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .fft_done(fft_done),
        .m_data(m_data_w[1]), .m_valid(m_valid_w[1]), .m_last(m_last_w[1]),
        .overrun(overrun_w[1]), .overrun_cnt(ovr_cnt_w[1])
    );

    // Reference model state, one slot per instance; expectations keyed by cycle*2+instance.
    int     fill_m [2];
    int     hop_m [2];
    int     stream_last_m [2];
    int     cnt_m [2];
    bit     busy_m [2];
    longint hist [$];
    bit     exp_v [int];
    bit     exp_l [int];
    longint exp_d [int];
    bit     exp_o [int];
    int     cyc;
    int     n_chk;
    int     n_fail;
    int     pulses0;
    int     lasts0;

    function automatic int hop_of(input int i);
        return (i == 0) ? 128 : 1;
    endfunction

`ifdef FRAMER_HANN_EN
    function automatic longint hann_ref(input longint s, input int k);
        real    c;
        longint w, p;
        c = $cos(2.0 * 3.14159265358979323846 * k / N);
        if ((c < 1.0e-9) && (c > -1.0e-9)) c = 0.0;
        w = longint'($floor(32767.0 * 0.5 * (1.0 - c) + 0.5));
        p = (s * w + 16384) >>> 15;
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        return p;
    endfunction
`endif

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic model_edge(input bit v, input longint d, input bit done);
        bit trig;
        int key;
        if (v) hist.push_back(d);
        for (int i = 0; i < 2; i++) begin
            trig = 1'b0;
            if (v) begin
                if (fill_m[i] < N) begin
                    fill_m[i]++;
                    trig = (fill_m[i] == N);
                end else begin
                    hop_m[i]++;
                    trig = (hop_m[i] == hop_of(i));
                end
                if (trig) hop_m[i] = 0;
            end
            if (trig && (cyc > stream_last_m[i]) && (!busy_m[i] || done)) begin
                busy_m[i]        = 1'b1;
                stream_last_m[i] = cyc + N - 1;
                for (int k = 0; k < N; k++) begin
                    key        = (cyc + 1 + k) * 2 + i;
                    exp_v[key] = 1'b1;
                    exp_l[key] = (k == N - 1);
`ifdef FRAMER_HANN_EN
                    exp_d[key] = hann_ref(hist[hist.size() - N + k], k);
`else
                    exp_d[key] = hist[hist.size() - N + k];
`endif
                end
            end else begin
                if (trig) begin
                    exp_o[cyc * 2 + i] = 1'b1;
                    if (cnt_m[i] < 65535) cnt_m[i]++;
                end
                if (done) busy_m[i] = 1'b0;
            end
        end
    endtask

    task automatic check_cycle();
        int key;
        bit ev;
        for (int i = 0; i < 2; i++) begin
            key = cyc * 2 + i;
            ev  = exp_v.exists(key) != 0;
            chk($sformatf("m_valid[%0d]", i), m_valid_w[i], ev);
            chk($sformatf("m_last[%0d]", i), m_last_w[i], ev ? exp_l[key] : 1'b0);
            if (ev) chk($sformatf("m_data[%0d]", i), m_data_w[i], exp_d[key]);
            chk($sformatf("overrun[%0d]", i), overrun_w[i], exp_o.exists(key) != 0);
            chk($sformatf("overrun_cnt[%0d]", i), ovr_cnt_w[i], cnt_m[i]);
        end
        if (overrun_w[0]) pulses0++;
        if (m_last_w[0]) lasts0++;
    endtask

    task automatic step(input bit v, input longint d, input bit done);
        s_valid  = v;
        s_data   = 16'(d);
        fft_done = done;
        model_edge(v, d, done);
        @(posedge clk);
        @(negedge clk);
        check_cycle();
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 0, 1'b0);
    endtask

    task automatic reset_pulse();
        s_valid  = 1'b0;
        fft_done = 1'b0;
        rst_n    = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_m_valid[%0d]", i), m_valid_w[i], 0);
            chk($sformatf("rst_m_last[%0d]", i), m_last_w[i], 0);
            chk($sformatf("rst_m_data[%0d]", i), m_data_w[i], 0);
            chk($sformatf("rst_overrun[%0d]", i), overrun_w[i], 0);
            chk($sformatf("rst_overrun_cnt[%0d]", i), ovr_cnt_w[i], 0);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            fill_m[i]        = 0;
            hop_m[i]         = 0;
            busy_m[i]        = 1'b0;
            stream_last_m[i] = -1;
            cnt_m[i]         = 0;
        end
        exp_v.delete();
        exp_l.delete();
        exp_d.delete();
        exp_o.delete();
    endtask

    initial begin
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        fft_done = 1'b0;
        n_chk    = 0;
        n_fail   = 0;
        cyc      = 0;
        pulses0  = 0;
        lasts0   = 0;
        repeat (3) @(negedge clk);
        reset_pulse();

        // N-1 samples: no frame yet; sample N-1 completes the fill and triggers frame 1.
        for (int k = 0; k < N - 1; k++) step(1'b1, k, 1'b0);
        step(1'b1, N - 1, 1'b0);
        idle(N + 4);
        chk("t2_frames", lasts0, 1);

        // FFT done, then one hop of new samples: frame 2 = samples 128..383.
        step(1'b0, 0, 1'b1);
        for (int k = N; k < N + 128; k++) step(1'b1, k, 1'b0);
        idle(N + 4);
        chk("t3_frames", lasts0, 2);
        chk("t3_overrun_cnt", ovr_cnt_w[0], 0);

        // FFT never finishes: both triggers in the next 256 samples are dropped.
        pulses0 = 0;
        for (int k = N + 128; k < 2 * N + 128; k++) step(1'b1, k, 1'b0);
        chk("t4_pulses", pulses0, 2);
        chk("t4_overrun_cnt", ovr_cnt_w[0], 2);

        // fft_done coincides with the trigger sample: accepted.
        for (int k = 2 * N + 128; k < 3 * N - 1; k++) step(1'b1, k, 1'b0);
        step(1'b1, 3 * N - 1, 1'b1);
        idle(N + 4);
        chk("t5_frames", lasts0, 3);
        chk("t5_overrun_cnt", ovr_cnt_w[0], 2);
        chk("t5_hop1_dropped", ovr_cnt_w[1] != 16'd0, 1);

        // Reset in the middle of a burst, then a fresh fill is required.
        step(1'b0, 0, 1'b1);
        for (int k = 3 * N; k < 3 * N + 128; k++) step(1'b1, k, 1'b0);
        idle(100);
        reset_pulse();
        lasts0 = 0;
        for (int k = 0; k < N - 1; k++) step(1'b1, 4096 + k, 1'b0);
        chk("t6_no_frame_before_fill", lasts0, 0);
        step(1'b1, 4096 + N - 1, 1'b0);
        idle(N + 4);
        chk("t6_frames", lasts0, 1);

        // Random traffic: gaps in s_valid, full-scale data, sporadic fft_done.
        for (int t = 0; t < 2500; t++) begin
            logic signed [15:0] r;
            r = 16'($urandom);
            step($urandom_range(0, 9) < 8, r, $urandom_range(0, 199) < 3);
        end
        idle(2 * N);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
